// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: bundles the run-controller signals shared between the sequencer and the
// core/environment side.
//   Start      : level request to run the full program sequence (environment -> sequencer)
//   Halt       : core reports the current program has finished (environment -> sequencer)
//   ProgSel    : current program index for the branch-target lookup
//   CoreReset  : reset to the core datapath, low only while a program runs
//   Busy       : a sequence is in progress
//   Done       : all programs have completed
//   CycleCount : RUN-cycle count of the last completed program
//   CountValid : one-cycle pulse when CycleCount/Timeout update
//   Timeout    : qualifies CountValid, set when the watchdog aborted the program
// Modports: master = sequencer side, slave = core/environment side.
interface prog_sequencer_if #(
    parameter int unsigned PROG_W = 3,
    parameter int unsigned CNT_W  = 16
);
    logic              Start;
    logic              Halt;
    logic [PROG_W-1:0] ProgSel;
    logic              CoreReset;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  CycleCount;
    logic              CountValid;
    logic              Timeout;

    modport master (
        input  Start, Halt,
        output ProgSel, CoreReset, Busy, Done, CycleCount, CountValid, Timeout
    );

    modport slave (
        output Start, Halt,
        input  ProgSel, CoreReset, Busy, Done, CycleCount, CountValid, Timeout
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: top-level run controller for the multi-program core. On Start it steps
// through programs 0..NUM_PROGS-1; for each one it holds the core in reset for RST_CYCLES
// cycles, releases it, counts RUN cycles until Halt, and reports the count. After the last
// program it reports Done.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : prog_sequencer_if.master (Start/Halt in; ProgSel, CoreReset, Busy, Done,
//           CycleCount, CountValid, Timeout out)
// Optional feature: define WATCHDOG_EN to abort a program after WDOG_LIMIT RUN cycles without
// Halt (reported with Timeout=1). Without it Timeout is tied low and RUN waits for Halt.
module prog_sequencer #(
    parameter int unsigned NUM_PROGS  = 3,
    parameter int unsigned PROG_W     = 3,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input logic              CLK,
    input logic              Reset,
    prog_sequencer_if.master bus
);
    localparam int unsigned       HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(NUM_PROGS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_PROGS < 1 || NUM_PROGS > 2 ** PROG_W) begin : g_bad_num_progs
        $error("prog_sequencer: NUM_PROGS out of range");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("prog_sequencer: RST_CYCLES must be at least 1");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
        $error("prog_sequencer: WDOG_LIMIT must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRstc,
        StRun,
        StLog,
        StFinish
    } state_e;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  run_q;
    logic [CNT_W-1:0]  run_k;
    logic [PROG_W-1:0] prog_sel_q;
    logic              core_reset_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              count_valid_q;

    // run_q counts completed RUN cycles, so run_k is the index of the current RUN cycle,
    // saturating at the counter maximum instead of wrapping.
    assign run_k = (run_q == {CNT_W{1'b1}}) ? run_q : run_q + CNT_W'(1);

`ifdef WATCHDOG_EN
    logic timeout_q;
    logic wdog_hit;

    assign wdog_hit = (32'(run_k) == WDOG_LIMIT);
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            run_q         <= '0;
            prog_sel_q    <= '0;
            core_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
`ifdef WATCHDOG_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                StIdle, StFinish: begin
                    if (bus.Start) begin
                        state_q    <= StRstc;
                        prog_sel_q <= '0;
                        hold_q     <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                StRstc: begin
                    hold_q <= hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= StRun;
                        run_q        <= '0;
                        core_reset_q <= 1'b0;
                    end
                end
                StRun: begin
                    // Halt wins over a watchdog expiry in the same cycle.
                    if (bus.Halt) begin
                        state_q       <= StLog;
                        cycle_count_q <= run_k;
                        count_valid_q <= 1'b1;
                        core_reset_q  <= 1'b1;
`ifdef WATCHDOG_EN
                        timeout_q     <= 1'b0;
`endif
                    end
`ifdef WATCHDOG_EN
                    else if (wdog_hit) begin
                        state_q       <= StLog;
                        cycle_count_q <= run_k;
                        count_valid_q <= 1'b1;
                        core_reset_q  <= 1'b1;
                        timeout_q     <= 1'b1;
                    end
`endif
                    else begin
                        run_q <= run_k;
                    end
                end
                StLog: begin
                    if (prog_sel_q == LAST_PROG) begin
                        state_q <= StFinish;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= StRstc;
                        prog_sel_q <= prog_sel_q + PROG_W'(1);
                        hold_q     <= '0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    core_reset_q <= 1'b1;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ProgSel    = prog_sel_q;
    assign bus.CoreReset  = core_reset_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.CycleCount = cycle_count_q;
    assign bus.CountValid = count_valid_q;
`ifdef WATCHDOG_EN
    assign bus.Timeout    = timeout_q;
`else
    assign bus.Timeout    = 1'b0;
`endif
endmodule
